// File: rtl/wb_tgt_ram.sv
// Pipelined Wishbone target RAM: commit on accept, in-order ack/err one or more cycles later (min 2 cycles after request).
// Back-pressure: STALL while outstanding == QD, a registered-state function with no input-to-output path.

module fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk_i,
  input  logic         sync_rst_n_i,
  input  logic         flush,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          wr_en;
  logic          rd_en;

  // cnt never exceeds the depth, so its MSB alone marks full
  assign wr_rdy = ~cnt[AW];
  assign rd_vld = (cnt != '0);
  assign rd_dat = mem[rd_ptr];
  assign wr_en  = wr_vld & wr_rdy;
  assign rd_en  = rd_vld & rd_rdy;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk_i) begin
    if (!sync_rst_n_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end
endmodule

module wb_tgt_ram #(
  parameter int ADR_WIDTH  = 4,
  parameter int DAT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TGRD_WIDTH = 1,
  parameter int TGWD_WIDTH = 1,
  parameter int QUE_AW     = 2
) (
  input  logic                  clk_i,
  input  logic                  sync_rst_n_i,
  input  logic                  tgt_cyc_i,
  input  logic                  tgt_stb_i,
  input  logic                  tgt_we_i,
  input  logic                  tgt_lock_i,
  input  logic [SEL_WIDTH-1:0]  tgt_sel_i,
  input  logic [ADR_WIDTH-1:0]  tgt_adr_i,
  input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
  input  logic [TGWD_WIDTH-1:0] tgt_tgd_i,
  output logic                  tgt_ack_o,
  output logic                  tgt_err_o,
  output logic                  tgt_rty_o,
  output logic                  tgt_stall_o,
  output logic [DAT_WIDTH-1:0]  tgt_dat_o,
  output logic [TGRD_WIDTH-1:0] tgt_tgd_o,
  input  logic                  resp_hold_i
);
  localparam int LW = DAT_WIDTH / SEL_WIDTH;
  localparam logic [QUE_AW:0] QD_CNT = {1'b1, {QUE_AW{1'b0}}};

  typedef struct packed {
    logic                  err;
    logic [DAT_WIDTH-1:0]  dat;
    logic [TGRD_WIDTH-1:0] tgd;
  } rsp_t;

  logic [DAT_WIDTH-1:0]  mem [2**ADR_WIDTH];
  logic [TGWD_WIDTH-1:0] tag [2**ADR_WIDTH];

  logic [QUE_AW:0]       outstanding;
  logic                  acc;
  logic                  sel_err;
  logic                  flush;
  logic                  rsp_done;
  logic                  q_vld;
  logic                  pop;
  logic                  q_wr_rdy_unused;
  logic                  lock_unused;
  logic [DAT_WIDTH-1:0]  wr_word;
  rsp_t                  push_ent;
  rsp_t                  head_ent;

  assign lock_unused = tgt_lock_i;
  assign tgt_rty_o   = 1'b0;
  assign tgt_stall_o = (outstanding == QD_CNT);
  assign acc         = tgt_cyc_i & tgt_stb_i & ~tgt_stall_o;
  assign sel_err     = (tgt_sel_i == '0);
  // Dropping cyc with work in flight abandons it; accepted writes stay committed
  assign flush       = ~tgt_cyc_i & (outstanding != '0);
  assign rsp_done    = tgt_ack_o | tgt_err_o;
  assign pop         = q_vld & ~resp_hold_i;

  always_comb begin
    wr_word = mem[tgt_adr_i];
    for (int i = 0; i < SEL_WIDTH; i++) begin
      if (tgt_sel_i[i]) wr_word[i*LW +: LW] = tgt_dat_i[i*LW +: LW];
    end
    push_ent = '0;
    if (sel_err) begin
      push_ent.err = 1'b1;
    end else if (!tgt_we_i) begin
      push_ent.dat = mem[tgt_adr_i];
      push_ent.tgd = tag[tgt_adr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_n_i && acc && tgt_we_i && !sel_err) begin
      mem[tgt_adr_i] <= wr_word;
      tag[tgt_adr_i] <= tgt_tgd_i;
    end
  end

  fifo #(
    .W  ($bits(rsp_t)),
    .AW (QUE_AW)
  ) u_rsp_q (
    .clk_i        (clk_i),
    .sync_rst_n_i (sync_rst_n_i),
    .flush        (flush),
    .wr_vld       (acc),
    .wr_rdy       (q_wr_rdy_unused),
    .wr_dat       (push_ent),
    .rd_vld       (q_vld),
    .rd_rdy       (~resp_hold_i),
    .rd_dat       (head_ent)
  );

  // Outstanding covers both queued entries and the one in the output stage
  always_ff @(posedge clk_i) begin
    if (!sync_rst_n_i || flush) begin
      tgt_ack_o   <= 1'b0;
      tgt_err_o   <= 1'b0;
      tgt_dat_o   <= '0;
      tgt_tgd_o   <= '0;
      outstanding <= '0;
    end else begin
      tgt_ack_o   <= pop & ~head_ent.err;
      tgt_err_o   <= pop & head_ent.err;
      tgt_dat_o   <= pop ? head_ent.dat : '0;
      tgt_tgd_o   <= pop ? head_ent.tgd : '0;
      outstanding <= outstanding + (QUE_AW+1)'(acc) - (QUE_AW+1)'(rsp_done);
    end
  end
endmodule

// File: doc/wb_tgt_ram.md
Name: wb_tgt_ram

Overview:
Pipelined Wishbone target RAM with an in-order response queue. It consumes the initiator-to-target bus that the WbXbc target monitor checks, and is the reference target the crossbar benches terminate each target port with. Requests are committed on acceptance and acknowledged in order one or more cycles later. Back-pressure is signalled through STALL when the outstanding-response queue is full.

Parameters:
ADR_WIDTH, 4, address width; memory holds 2**ADR_WIDTH words.
DAT_WIDTH, 16, data width.
SEL_WIDTH, 2, select lines; each covers DAT_WIDTH/SEL_WIDTH bits.
TGRD_WIDTH, 1, read data tag width; must equal TGWD_WIDTH.
TGWD_WIDTH, 1, write data tag width.
QUE_AW, 2, response queue address width; queue depth QD = 2**QUE_AW.

Ports:
clk_i  in  1  module clock
sync_rst_n_i  in  1  reset; synchronous, active-low
tgt_cyc_i  in  1  bus cycle indicator
tgt_stb_i  in  1  access request
tgt_we_i  in  1  write enable
tgt_lock_i  in  1  uninterruptable cycle; ignored
tgt_sel_i  in  SEL_WIDTH  byte-lane selects
tgt_adr_i  in  ADR_WIDTH  word address
tgt_dat_i  in  DAT_WIDTH  write data
tgt_tgd_i  in  TGWD_WIDTH  write data tag
tgt_ack_o  out  1  acknowledge
tgt_err_o  out  1  error termination
tgt_rty_o  out  1  retry; constant 0
tgt_stall_o  out  1  request not accepted
tgt_dat_o  out  DAT_WIDTH  read data
tgt_tgd_o  out  TGRD_WIDTH  read data tag
resp_hold_i  in  1  bench throttle; 1 blocks response issue

Behaviour:
- Reset (sync_rst_n_i=0 at posedge): all outputs 0, queue emptied, outstanding count 0. Memory contents are not reset. Reset overrides every other event in the same cycle, including any accept and any pop.
- Accept condition: acc = tgt_cyc_i & tgt_stb_i & ~tgt_stall_o. At most one request is accepted per cycle.
- tgt_stall_o = (outstanding == QD), where outstanding counts accepted but not yet acknowledged requests. It is a function of registered state only, so there is no combinational path from the inputs. Stall stays asserted in a cycle where a pop frees a slot; the freed slot is usable from the next cycle.
- Error request: tgt_sel_i == 0 at accept. Memory is untouched and an err entry is queued.
- Write, sel != 0: at the accept edge, each lane i with sel[i]=1 is written; the stored tag is replaced with tgt_tgd_i. An ack entry is queued with data 0 and tag 0.
- Read, sel != 0: at the accept edge, the full word and its tag are captured into an ack entry. A read accepted in the cycle after a write to the same address returns the new data.
- Queue: FIFO of {err, dat, tgd}, QD entries, with wrapping read/write pointers. A push and a pop in the same cycle leave the count unchanged.
- Response issue (pop): a registered output stage. In any cycle with the queue non-empty and resp_hold_i=0, the head entry is popped into the output registers.
  - Popping sets tgt_ack_o or tgt_err_o to 1 for exactly the next cycle, with tgt_dat_o/tgt_tgd_o valid in that same cycle.
  - Otherwise ack, err, dat and tgd are all 0.
  - Minimum latency: accepted at edge k, popped at edge k+1, ack visible in the cycle following edge k+1. Throughput is 1 response per cycle.
- At most one of ack/err is high in any cycle. Both are never asserted while outstanding == 0.
- An accepted entry must be able to pop in the cycle it lands in the queue. This permits the head to be bypassed when the queue is empty.
- Responses are issued strictly in acceptance order.
- Abort: tgt_cyc_i=0 while outstanding > 0 flushes the queue and the output stage at the next edge. No further ack/err is produced for the aborted requests, and writes already accepted remain committed. A flush and a new accept cannot coincide because cyc is low.
- tgt_cyc_i must not be low while ack is pending; if it is, the queue is flushed. The block contains no assertions.
- Counter width is QUE_AW+1, and the count never exceeds QD.

Test Plan:
1. Write adr=3 dat=0xA55A sel=2'b11 tgd=1, then read adr=3 -> write ack 2 cycles after request cycle with dat_o=0; read ack returns dat_o=0xA55A, tgd_o=1.
2. Byte lanes: write adr=5 0x1234 sel=11, write adr=5 0xFFFF sel=01, read adr=5 -> dat_o=0x12FF.
3. Pipelined reads adr 0,1,2,3 on consecutive cycles (preloaded 0x10..0x13) -> 4 consecutive ack cycles, data 0x10,0x11,0x12,0x13 in order, stall never asserted.
4. resp_hold_i=1, issue 6 back-to-back reads -> stall_o high after 4 accepts (QD=4); release hold -> 4 acks, stall drops, and the 2 remaining reads are accepted and acked.
5. Request with sel=2'b00 between two reads -> err_o for exactly the middle response, ack for the others, memory unchanged.
6. Hold with 3 outstanding, drop tgt_cyc_i for 1 cycle -> no ack/err afterwards, stall_o=0. A subsequent read returns data from a write accepted before the abort. Assert reset during a full queue -> all outputs 0 the next cycle.
